// File: rtl/mac_layer_sequencer_if.sv
// Runner-side bus of the MAC layer sequencer: launch pulse, per-channel configuration and result return.
// master = sequencer, slave = MAC block runner.
interface mac_layer_sequencer_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int MO_WIDTH   = 32
);
  logic                       run_start;
  logic [ADDR_WIDTH-1:0]      run_num;
  logic signed [31:0]         run_bias;
  logic signed [MO_WIDTH-1:0] run_m0;
  logic [5:0]                 run_n;
  logic                       run_done_in;
  logic signed [7:0]          run_result_in;

  modport master (
    output run_start, run_num, run_bias, run_m0, run_n,
    input  run_done_in, run_result_in
  );

  modport slave (
    input  run_start, run_num, run_bias, run_m0, run_n,
    output run_done_in, run_result_in
  );
endinterface

// File: rtl/mac_layer_sequencer.sv
// mac_layer_sequencer: drives one MAC block runner pass per output channel of a fully-connected layer.
// Define SEQ_PERF_CNT_EN to add the cycles_out busy-cycle counter port.
module mac_layer_sequencer #(
  parameter int ADDR_WIDTH = 10,
  parameter int CH_WIDTH   = 8,
  parameter int MO_WIDTH   = 32,
  parameter int PARAM_LAT  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_in,
  input  logic                       abort_in,
  input  logic [CH_WIDTH-1:0]        num_ch_in,
  input  logic [ADDR_WIDTH-1:0]      num_in,
  output logic [CH_WIDTH-1:0]        param_addr,
  input  logic signed [31:0]         param_bias_in,
  input  logic signed [MO_WIDTH-1:0] param_m0_in,
  input  logic [5:0]                 param_n_in,
  output logic                       out_we,
  output logic [CH_WIDTH-1:0]        out_addr,
  output logic signed [7:0]          out_data,
  output logic                       busy,
  output logic                       done,
  output logic                       err_out,
`ifdef SEQ_PERF_CNT_EN
  output logic [31:0]                cycles_out,
`endif
  mac_layer_sequencer_if.master      run_if
);

  localparam int LAT_W = (PARAM_LAT > 1) ? $clog2(PARAM_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PFETCH,
    S_LAUNCH,
    S_RUN,
    S_WRITE,
    S_GAP,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                       r_startPrev;
  logic                       r_donePrev;
  logic [CH_WIDTH-1:0]        r_ch;
  logic [CH_WIDTH-1:0]        r_numCh;
  logic [LAT_W-1:0]           r_lat;
  logic signed [7:0]          r_result;
  logic                       r_done;
  logic                       r_err;
  logic [ADDR_WIDTH-1:0]      r_runNum;
  logic signed [31:0]         r_runBias;
  logic signed [MO_WIDTH-1:0] r_runM0;
  logic [5:0]                 r_runN;

  logic w_idle;
  logic w_startEdge;
  logic w_accept;
  logic w_abort;
  logic w_runDoneEdge;
  logic w_latDone;
  logic w_lastCh;
  logic w_zeroLayer;

  assign w_idle        = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_startEdge   = start_in & ~r_startPrev;
  assign w_accept      = w_idle & w_startEdge;
  assign w_abort       = abort_in & ~w_idle;
  // The runner holds done from the previous channel, so only a fresh rising edge counts.
  assign w_runDoneEdge = run_if.run_done_in & ~r_donePrev;
  assign w_latDone     = (r_lat == LAT_W'(PARAM_LAT - 1));
  assign w_lastCh      = (r_ch == (r_numCh - CH_WIDTH'(1)));
  assign w_zeroLayer   = (num_in == '0) || (num_ch_in == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (w_abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            w_next = w_zeroLayer ? S_DONE : S_PFETCH;
          end
        end
        S_PFETCH: if (w_latDone) w_next = S_LAUNCH;
        S_LAUNCH: w_next = S_RUN;
        S_RUN:    if (w_runDoneEdge) w_next = S_WRITE;
        S_WRITE:  w_next = w_lastCh ? S_DONE : S_GAP;
        S_GAP:    w_next = S_PFETCH;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_startPrev <= 1'b0;
      r_donePrev  <= 1'b0;
      r_ch        <= '0;
      r_numCh     <= '0;
      r_lat       <= '0;
      r_result    <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_runNum    <= '0;
      r_runBias   <= '0;
      r_runM0     <= '0;
      r_runN      <= '0;
    end else begin
      r_startPrev <= start_in;
      r_donePrev  <= run_if.run_done_in;
      if ((r_state == S_PFETCH) && !w_latDone && !w_abort) begin
        r_lat <= r_lat + LAT_W'(1);
      end else begin
        r_lat <= '0;
      end
      if (w_accept) begin
        r_numCh  <= num_ch_in;
        r_runNum <= num_in;
        r_ch     <= '0;
        r_err    <= (num_in == '0);
        r_done   <= w_zeroLayer;
      end else if (!w_abort) begin
        case (r_state)
          S_PFETCH: begin
            if (w_latDone) begin
              r_runBias <= param_bias_in;
              r_runM0   <= param_m0_in;
              r_runN    <= param_n_in;
            end
          end
          S_RUN: if (w_runDoneEdge) r_result <= run_if.run_result_in;
          S_WRITE: begin
            if (w_lastCh) r_done <= 1'b1;
            else          r_ch   <= r_ch + CH_WIDTH'(1);
          end
          default: ;
        endcase
      end
    end
  end

  // The first channel's address is shown during the accepting cycle so the fetch window stays PARAM_LAT long.
  assign param_addr       = w_accept ? '0 : r_ch;
  assign run_if.run_start = (r_state == S_LAUNCH) & ~abort_in;
  assign run_if.run_num   = r_runNum;
  assign run_if.run_bias  = r_runBias;
  assign run_if.run_m0    = r_runM0;
  assign run_if.run_n     = r_runN;
  assign out_we           = (r_state == S_WRITE) & ~abort_in;
  assign out_addr         = r_ch;
  assign out_data         = r_result;
  assign busy             = ~w_idle;
  assign done             = r_done;
  assign err_out          = r_err;

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] r_cycles;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycles <= '0;
    end else if (w_accept) begin
      r_cycles <= '0;
    end else if (!w_idle && (r_cycles != 32'hFFFF_FFFF)) begin
      r_cycles <= r_cycles + 32'd1;
    end
  end

  assign cycles_out = r_cycles;
`endif

endmodule

// File: tb/tb_mac_layer_sequencer.sv
// Self-checking bench for mac_layer_sequencer with a param BRAM model and a behavioural MAC runner model.
// Honours SEQ_PERF_CNT_EN to also check the cycles_out counter.
module tb_mac_layer_sequencer;
  localparam int ADDR_WIDTH = 10;
  localparam int CH_WIDTH   = 8;
  localparam int MO_WIDTH   = 32;
  localparam int PARAM_LAT  = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  startIn = 1'b0;
  logic                  abortIn = 1'b0;
  logic [CH_WIDTH-1:0]   numChIn = '0;
  logic [ADDR_WIDTH-1:0] numIn = '0;
  logic [CH_WIDTH-1:0]   paramAddr;
  logic [31:0]           paramBias;
  logic [MO_WIDTH-1:0]   paramM0;
  logic [5:0]            paramN;
  logic                  outWe;
  logic [CH_WIDTH-1:0]   outAddr;
  logic [7:0]            outData;
  logic                  busy;
  logic                  done;
  logic                  errOut;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0]           cyclesOut;
`endif

  int checks = 0;
  int errors = 0;

  mac_layer_sequencer_if #(.ADDR_WIDTH(ADDR_WIDTH), .MO_WIDTH(MO_WIDTH)) runIf ();

  mac_layer_sequencer #(
    .ADDR_WIDTH(ADDR_WIDTH), .CH_WIDTH(CH_WIDTH), .MO_WIDTH(MO_WIDTH), .PARAM_LAT(PARAM_LAT)
  ) dut (
    .clk(clk), .rst(rst), .start_in(startIn), .abort_in(abortIn),
    .num_ch_in(numChIn), .num_in(numIn), .param_addr(paramAddr),
    .param_bias_in(paramBias), .param_m0_in(paramM0), .param_n_in(paramN),
    .out_we(outWe), .out_addr(outAddr), .out_data(outData),
    .busy(busy), .done(done), .err_out(errOut),
`ifdef SEQ_PERF_CNT_EN
    .cycles_out(cyclesOut),
`endif
    .run_if(runIf)
  );

  always #5 clk = ~clk;

  // Param BRAM: data for an address appears PARAM_LAT clock edges after it is presented.
  logic [31:0]         memBias [256];
  logic [MO_WIDTH-1:0] memM0 [256];
  logic [5:0]          memN [256];
  logic [CH_WIDTH-1:0] addrPipe [PARAM_LAT];

  always @(posedge clk) begin
    addrPipe[0] <= paramAddr;
    for (int k = 1; k < PARAM_LAT; k++) addrPipe[k] <= addrPipe[k-1];
  end
  assign paramBias = memBias[addrPipe[PARAM_LAT-1]];
  assign paramM0   = memM0[addrPipe[PARAM_LAT-1]];
  assign paramN    = memN[addrPipe[PARAM_LAT-1]];

  function automatic logic [7:0] runnerFn(logic [31:0] b, logic [31:0] m, logic [5:0] n, logic [9:0] num);
    logic [31:0] t;
    t = (b ^ m) + 32'(n) + 32'(num);
    return t[7:0];
  endfunction

  // Runner: done rises runLat edges after it samples run_start and is held until the next start.
  int          runLat = 4;
  bit          holdDoneExtra = 1'b0;
  int          runCnt;
  bit          clearPending;
  logic        runDone;
  logic [7:0]  runResult;
  logic [7:0]  pendingResult;

  assign runIf.run_done_in   = runDone;
  assign runIf.run_result_in = runResult;

  always @(posedge clk) begin
    if (rst) begin
      runCnt <= 0; runDone <= 1'b0; runResult <= '0; pendingResult <= '0; clearPending <= 1'b0;
    end else begin
      if (clearPending) begin
        runDone <= 1'b0; clearPending <= 1'b0;
      end
      if (runIf.run_start) begin
        runCnt <= runLat;
        if (holdDoneExtra) clearPending <= 1'b1;
        else               runDone <= 1'b0;
        pendingResult <= runnerFn(runIf.run_bias, runIf.run_m0, runIf.run_n, runIf.run_num);
      end else if (runCnt > 0) begin
        runCnt <= runCnt - 1;
        if (runCnt == 1) begin
          runDone <= 1'b1; runResult <= pendingResult;
        end
      end
    end
  end

  logic [31:0]           lBiasQ[$];
  logic [31:0]           lM0Q[$];
  logic [5:0]            lNQ[$];
  logic [ADDR_WIDTH-1:0] lNumQ[$];
  logic [CH_WIDTH-1:0]   wrAddrQ[$];
  logic [7:0]            wrDataQ[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (runIf.run_start) begin
        lBiasQ.push_back(runIf.run_bias); lM0Q.push_back(runIf.run_m0);
        lNQ.push_back(runIf.run_n);       lNumQ.push_back(runIf.run_num);
      end
      if (outWe) begin
        wrAddrQ.push_back(outAddr); wrDataQ.push_back(outData);
      end
    end
  end

  typedef struct {
    int numCh;
    int num;
    int lat;
    int expWrites;
    bit expErr;
  } vec_t;

  vec_t vecs[6];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int nCh, input int nNum);
    lBiasQ.delete(); lM0Q.delete(); lNQ.delete(); lNumQ.delete();
    wrAddrQ.delete(); wrDataQ.delete();
    @(negedge clk);
    numChIn = CH_WIDTH'(nCh); numIn = ADDR_WIDTH'(nNum); startIn = 1'b1;
    @(negedge clk);
    startIn = 1'b0;
  endtask

  task automatic waitDone(input string name, input int budget);
    int k = 0;
    while (!done && k < budget) begin
      @(negedge clk); k++;
    end
    checkOutput({name, " done reached"}, 64'(done), 64'd1);
  endtask

  task automatic waitLaunches(input string name, input int n, input int budget);
    int k = 0;
    while (lBiasQ.size() < n && k < budget) begin
      @(negedge clk); k++;
    end
    checkOutput({name, " launch reached"}, 64'(lBiasQ.size() >= n), 64'd1);
  endtask

  // Expected writes are channels 0..expW-1 with the runner function applied to each channel's params.
  task automatic verifyLayer(input string name, input int nNum, input int expW, input bit expErr);
    logic [ADDR_WIDTH-1:0] numL;
    numL = ADDR_WIDTH'(nNum);
    checkOutput({name, " write count"}, 64'(wrAddrQ.size()), 64'(expW));
    checkOutput({name, " launch count"}, 64'(lBiasQ.size()), 64'(expW));
    for (int i = 0; i < expW && i < wrAddrQ.size(); i++) begin
      checkOutput($sformatf("%s addr[%0d]", name, i), 64'(wrAddrQ[i]), 64'(i));
      checkOutput($sformatf("%s data[%0d]", name, i), 64'(wrDataQ[i]),
                  64'(runnerFn(memBias[i], memM0[i], memN[i], numL)));
    end
    for (int i = 0; i < expW && i < lBiasQ.size(); i++) begin
      checkOutput($sformatf("%s run_bias[%0d]", name, i), 64'(lBiasQ[i]), 64'(memBias[i]));
      checkOutput($sformatf("%s run_m0[%0d]", name, i), 64'(lM0Q[i]), 64'(memM0[i]));
      checkOutput($sformatf("%s run_n[%0d]", name, i), 64'(lNQ[i]), 64'(memN[i]));
      checkOutput($sformatf("%s run_num[%0d]", name, i), 64'(lNumQ[i]), 64'(numL));
    end
    checkOutput({name, " done"}, 64'(done), 64'd1);
    checkOutput({name, " busy"}, 64'(busy), 64'd0);
    checkOutput({name, " err"}, 64'(errOut), 64'(expErr));
  endtask

  task automatic runLayer(input string name, input int nCh, input int nNum, input int lat,
                          input bit hold, input int expW, input bit expErr);
    runLat = lat; holdDoneExtra = hold;
    applyStimulus(nCh, nNum);
    waitDone(name, nCh * (PARAM_LAT + 6 + lat) + 40);
    verifyLayer(name, nNum, expW, expErr);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      memBias[i] = $urandom; memM0[i] = $urandom; memN[i] = 6'($urandom);
    end
    memBias[0] = 32'd100;
    memBias[1] = 32'hFFFF_FFFB;

    vecs[0] = '{numCh: 4,   num: 8,    lat: 20, expWrites: 4,   expErr: 1'b0};
    vecs[1] = '{numCh: 0,   num: 5,    lat: 3,  expWrites: 0,   expErr: 1'b0};
    vecs[2] = '{numCh: 3,   num: 0,    lat: 3,  expWrites: 0,   expErr: 1'b1};
    vecs[3] = '{numCh: 1,   num: 1,    lat: 1,  expWrites: 1,   expErr: 1'b0};
    vecs[4] = '{numCh: 255, num: 1023, lat: 1,  expWrites: 255, expErr: 1'b0};
    vecs[5] = '{numCh: 0,   num: 0,    lat: 2,  expWrites: 0,   expErr: 1'b1};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    checkOutput("reset err", 64'(errOut), 64'd0);
    checkOutput("reset out_we", 64'(outWe), 64'd0);
    checkOutput("reset run_start", 64'(runIf.run_start), 64'd0);
    checkOutput("reset param_addr", 64'(paramAddr), 64'd0);
    checkOutput("reset out_data", 64'(outData), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      runLayer($sformatf("vec%0d", v), vecs[v].numCh, vecs[v].num, vecs[v].lat, 1'b0,
               vecs[v].expWrites, vecs[v].expErr);
    end

    runLayer("heldDone", 3, 12, 4, 1'b1, 3, 1'b0);

    for (int r = 0; r < 6; r++) begin
      int nCh, nNum, lat;
      bit hold;
      for (int i = 0; i < 16; i++) begin
        memBias[i] = $urandom; memM0[i] = $urandom; memN[i] = 6'($urandom);
      end
      nCh = $urandom_range(1, 10); nNum = $urandom_range(1, 1023);
      hold = 1'($urandom_range(0, 1));
      lat = $urandom_range(2, 8);
      runLayer($sformatf("rand%0d", r), nCh, nNum, lat, hold, nCh, 1'b0);
    end

    // Abort while channel 2 of 5 is running.
    runLat = 20; holdDoneExtra = 1'b0;
    applyStimulus(5, 33);
    waitLaunches("abortRun", 3, 200);
    repeat (3) @(negedge clk);
    abortIn = 1'b1;
    @(negedge clk);
    abortIn = 1'b0;
    checkOutput("abortRun busy", 64'(busy), 64'd0);
    checkOutput("abortRun done", 64'(done), 64'd0);
    repeat (30) @(negedge clk);
    checkOutput("abortRun writes", 64'(wrAddrQ.size()), 64'd2);
    if (wrAddrQ.size() == 2) begin
      checkOutput("abortRun addr0", 64'(wrAddrQ[0]), 64'd0);
      checkOutput("abortRun addr1", 64'(wrAddrQ[1]), 64'd1);
    end
    checkOutput("abortRun done later", 64'(done), 64'd0);
    runLayer("restart", 5, 33, 4, 1'b0, 5, 1'b0);

    // Abort in the very cycle the runner's done edge arrives.
    runLat = 5;
    applyStimulus(2, 17);
    waitLaunches("abortEdge", 1, 100);
    begin
      int k = 0;
      while (runDone && k < 50) begin @(negedge clk); k++; end
      k = 0;
      while (!runDone && k < 50) begin @(negedge clk); k++; end
      checkOutput("abortEdge runner done seen", 64'(runDone), 64'd1);
    end
    abortIn = 1'b1;
    @(negedge clk);
    abortIn = 1'b0;
    checkOutput("abortEdge busy", 64'(busy), 64'd0);
    repeat (5) @(negedge clk);
    checkOutput("abortEdge writes", 64'(wrAddrQ.size()), 64'd0);

    // A second start edge mid-layer must not disturb the running layer.
    runLat = 6;
    applyStimulus(3, 7);
    waitLaunches("startBusy", 1, 100);
    numChIn = 8'd9; numIn = 10'd50; startIn = 1'b1;
    @(negedge clk);
    startIn = 1'b0;
    waitDone("startBusy", 200);
    verifyLayer("startBusy", 7, 3, 1'b0);

    abortIn = 1'b1;
    @(negedge clk);
    abortIn = 1'b0;
    @(negedge clk);
    checkOutput("abortIdle done", 64'(done), 64'd1);
    checkOutput("abortIdle busy", 64'(busy), 64'd0);

    // Reset in the middle of a layer.
    memBias[0] = 32'd7; memM0[0] = 32'd0; memN[0] = 6'd1;
    runLat = 3;
    applyStimulus(4, 9);
    begin
      int k = 0;
      while (wrAddrQ.size() < 1 && k < 100) begin @(negedge clk); k++; end
      checkOutput("midReset first write", 64'(wrAddrQ.size() >= 1), 64'd1);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midReset busy", 64'(busy), 64'd0);
    checkOutput("midReset done", 64'(done), 64'd0);
    checkOutput("midReset out_data", 64'(outData), 64'd0);
    checkOutput("midReset out_we", 64'(outWe), 64'd0);
    checkOutput("midReset param_addr", 64'(paramAddr), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    runLayer("afterReset", 4, 9, 3, 1'b0, 4, 1'b0);

`ifdef SEQ_PERF_CNT_EN
    // Runner: 1 cycle start register + 10 compute + 1 done register.
    runLayer("perf", 1, 8, 12, 1'b0, 1, 1'b0);
    checkOutput("perf cycles", 64'(cyclesOut), 64'd17);
    repeat (5) @(negedge clk);
    checkOutput("perf cycles held", 64'(cyclesOut), 64'd17);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
